gate_response_checker: RTL and testbench
========================================

Name: gate_response_checker

Overview:
- Response-side counterpart to the gate stimulus generators used with the logic-gate cells (AND/OR/XOR families).
- Consumes each applied operand pair (a, b) and the DUT's returned output z.
- Computes the expected gate result per bit, then counts samples and mismatches over a fixed-length run.
- Captures the first failing sample and reports pass/fail at the end of the run. Sits next to any WIDTH-parameterised gate in simulation or on-chip self-test.

Parameters:
- WIDTH, 5, operand/result bit width (≥2).
- NUM_SAMPLES, 10, samples per run (1 … 2^CNT_W−1).
- CNT_W, 8, width of the sample/error counters and the first-error index.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, begin a run; honoured only in IDLE or DONE.
- op, input, 3, gate select, latched at start: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR; 6 and 7 are treated as AND.
- in_valid, input, 1, a/b/z form one sample this cycle.
- a, input, WIDTH, operand A as applied to the DUT.
- b, input, WIDTH, operand B as applied to the DUT.
- z, input, WIDTH, DUT output for this a/b.
- busy, output, 1, high in RUN.
- done, output, 1, high in DONE.
- pass, output, 1, valid when done; 1 iff err_cnt==0.
- sample_cnt, output, CNT_W, samples accepted this run.
- err_cnt, output, CNT_W, mismatching samples; saturates at all-ones.
- first_err_idx, output, CNT_W, 0-based index of the first mismatching sample.
- first_err_exp, output, WIDTH, expected value at the first mismatch.
- first_err_got, output, WIDTH, z observed at the first mismatch.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset: state IDLE; every output is 0, including pass; latched op is 0. rst asserted mid-run aborts the run the same edge, with no partial results retained.
- FSM states are IDLE, RUN and DONE.
  - IDLE, start=1 → RUN. Clear counters and first-error fields, latch op.
  - RUN, in_valid=1 → accept the sample.
    - exp = f(a,b) per latched op, computed bitwise on the full WIDTH.
    - sample_cnt increments.
    - If z≠exp: err_cnt increments (saturating). If this is the first mismatch of the run, capture first_err_idx = pre-increment sample_cnt, first_err_exp = exp, first_err_got = z.
    - Results are visible the cycle after the accepting edge.
  - RUN, accepted sample is the NUM_SAMPLES-th → DONE on the same edge. done=1 and busy=0 from the next cycle; pass = (final err_cnt==0).
  - DONE: all results held. start=1 → RUN with the same clearing as from IDLE. Back-to-back runs are allowed, with one DONE cycle minimum.
- start asserted in RUN is ignored; op changes in RUN are ignored.
- in_valid is ignored in IDLE and DONE. No sample is accepted on the start edge.
- in_valid may have gaps; only asserted cycles count.
- A start and an in_valid in the same cycle (in IDLE/DONE): start wins, the sample is dropped.
- When no mismatch occurs, first_err_* remain 0.

Optional Feature:
- Macro: GATE_CHECKER_SIGNATURE_EN.
- Defined:
  - Adds output port signature (WIDTH), a MISR over z for accepted samples.
  - Update: sig ← ({sig[WIDTH-2:0],0} XOR (sig[WIDTH-1] ? {0…0,1,1} : 0)) XOR z.
  - Cleared to 0 at reset and at start; held in DONE.
- Not defined: no signature port and no MISR logic. All other behaviour is identical.

Test Plan:
- Reset then idle: rst for 2 cycles, then 5 cycles with in_valid=1 and no start → all outputs 0, sample_cnt stays 0.
- Clean AND run (NUM_SAMPLES=10, op=0): 10 samples with z=a&b, e.g. a=5'h1B, b=5'h0E, z=5'h0A → done=1 one cycle after the 10th sample, sample_cnt=10, err_cnt=0, pass=1, first_err_*=0.
- Injected fault (op=2 XOR): samples 0–9 correct except sample 3, where a=5'h1B, b=5'h0E, z=5'h14 (exp 5'h15) → err_cnt=1, pass=0, first_err_idx=3, first_err_exp=5'h15, first_err_got=5'h14. A second fault at sample 7 leaves first_err_* unchanged and gives err_cnt=2.
- Gapped valid plus mid-run reset: in_valid toggled every other cycle; after 4 samples, rst for 1 cycle → IDLE, all outputs 0. A subsequent start is followed by a full clean run → pass=1.
- Restart from DONE, with start asserted in RUN: after a failing run, start with op=3 NAND and 10 correct samples (a=5'h1F, b=5'h01, z=5'h1E) → counters cleared, pass=1. A start pulse asserted mid-run has no effect.
- With GATE_CHECKER_SIGNATURE_EN: after start, samples z=5'h0A then z=5'h01 → signature 5'h0A, then 5'h15. rst → 0.

Source files
------------

// File: rtl/gate_response_checker.sv
// Response checker for AND/OR/XOR-family gates: counts samples and mismatches over a run
// and captures the first failure. Define GATE_CHECKER_SIGNATURE_EN to add a MISR signature output.
module gate_response_checker #(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned NUM_SAMPLES = 10,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_got
`ifdef GATE_CHECKER_SIGNATURE_EN
  ,
  output logic [WIDTH-1:0] signature
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] exp_val;
  logic             mismatch;
  logic             accept;
  logic             restart;

  always_comb begin
    exp_val = a & b;
    case (op_q)
      3'd1:    exp_val = a | b;
      3'd2:    exp_val = a ^ b;
      3'd3:    exp_val = ~(a & b);
      3'd4:    exp_val = ~(a | b);
      3'd5:    exp_val = ~(a ^ b);
      default: exp_val = a & b;
    endcase
  end

  assign mismatch = (z != exp_val);
  assign accept   = (state == RUN) && in_valid;
  assign restart  = (state != RUN) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      op_q          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      sample_cnt    <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else if (restart) begin
      state         <= RUN;
      op_q          <= op;
      busy          <= 1'b1;
      done          <= 1'b0;
      pass          <= 1'b0;
      sample_cnt    <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else if (accept) begin
      sample_cnt <= sample_cnt + 1'b1;
      if (mismatch) begin
        if (err_cnt != '1)
          err_cnt <= err_cnt + 1'b1;
        // err_cnt saturates rather than wrapping, so zero reliably marks "no failure yet"
        if (err_cnt == '0) begin
          first_err_idx <= sample_cnt;
          first_err_exp <= exp_val;
          first_err_got <= z;
        end
      end
      if (sample_cnt == LAST_IDX) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        pass  <= (err_cnt == '0) && !mismatch;
      end
    end
  end

`ifdef GATE_CHECKER_SIGNATURE_EN
  always_ff @(posedge clk) begin
    if (rst || restart)
      signature <= '0;
    else if (accept)
      signature <= {signature[WIDTH-2:0], 1'b0}
                   ^ (signature[WIDTH-1] ? WIDTH'(3) : '0)
                   ^ z;
  end
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed self-checking bench for gate_response_checker (default parameters, WIDTH=5, 10 samples).
module tb_gate_response_checker;

  localparam int unsigned WIDTH = 5;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       op = 3'd0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0, z = '0;
  logic             busy, done, pass;
  logic [CNT_W-1:0] sample_cnt, err_cnt, first_err_idx;
  logic [WIDTH-1:0] first_err_exp, first_err_got;
`ifdef GATE_CHECKER_SIGNATURE_EN
  logic [WIDTH-1:0] signature;
`endif

  int vectors = 0;
  int miscompares = 0;

  localparam logic [4:0] TA [10] = '{5'h1B, 5'h1F, 5'h00, 5'h15, 5'h0A, 5'h1C, 5'h03, 5'h11, 5'h1E, 5'h07};
  localparam logic [4:0] TB [10] = '{5'h0E, 5'h13, 5'h1F, 5'h0F, 5'h0A, 5'h07, 5'h1D, 5'h11, 5'h01, 5'h18};
  localparam logic [4:0] TAND [10] = '{5'h0A, 5'h13, 5'h00, 5'h05, 5'h0A, 5'h04, 5'h01, 5'h11, 5'h00, 5'h00};
  localparam logic [4:0] TXOR [10] = '{5'h15, 5'h0C, 5'h1F, 5'h1A, 5'h00, 5'h1B, 5'h1E, 5'h00, 5'h1F, 5'h1F};

  gate_response_checker #(.WIDTH(WIDTH), .NUM_SAMPLES(10), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .in_valid(in_valid),
    .a(a), .b(b), .z(z), .busy(busy), .done(done), .pass(pass),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt), .first_err_idx(first_err_idx),
    .first_err_exp(first_err_exp), .first_err_got(first_err_got)
`ifdef GATE_CHECKER_SIGNATURE_EN
    , .signature(signature)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [2:0] o);
    start = 1'b1; op = o;
    cyc();
    start = 1'b0;
  endtask

  task automatic sample(input logic [4:0] sa, input logic [4:0] sb, input logic [4:0] sz);
    in_valid = 1'b1; a = sa; b = sb; z = sz;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = 5'h1B; b = 5'h0E; z = 5'h1F;
    cyc(); cyc();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      vectors++;
      if ({busy, done, pass, sample_cnt, err_cnt} !== '0) begin
        miscompares++;
        $display("FAIL reset_idle cyc%0d: busy/done/pass=%b%b%b sample_cnt=%0d err_cnt=%0d, want all 0",
                 i, busy, done, pass, sample_cnt, err_cnt);
      end
    end
    vectors++;
    if ({first_err_idx, first_err_exp, first_err_got} !== '0) begin
      miscompares++;
      $display("FAIL reset_first_err: idx=%0d exp=%h got=%h, want 0", first_err_idx, first_err_exp, first_err_got);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_clean_and();
    do_start(3'd0);
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0 || sample_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL and_start: busy=%b done=%b sample_cnt=%0d, want 1 0 0", busy, done, sample_cnt);
    end
    for (int i = 0; i < 10; i++) begin
      sample(TA[i], TB[i], TAND[i]);
      if (i == 8) begin
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0 || sample_cnt !== 8'd9) begin
          miscompares++;
          $display("FAIL and_ninth: busy=%b done=%b sample_cnt=%0d, want 1 0 9", busy, done, sample_cnt);
        end
      end
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1 || sample_cnt !== 8'd10 || err_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL and_done: done=%b busy=%b pass=%b sample_cnt=%0d err_cnt=%0d, want 1 0 1 10 0",
               done, busy, pass, sample_cnt, err_cnt);
    end
    vectors++;
    if ({first_err_idx, first_err_exp, first_err_got} !== '0) begin
      miscompares++;
      $display("FAIL and_first_err: idx=%0d exp=%h got=%h, want 0", first_err_idx, first_err_exp, first_err_got);
    end
    // samples in DONE must be ignored
    sample(5'h1F, 5'h1F, 5'h00);
    vectors++;
    if (sample_cnt !== 8'd10 || err_cnt !== 8'd0 || pass !== 1'b1 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_hold: sample_cnt=%0d err_cnt=%0d pass=%b done=%b, want 10 0 1 1",
               sample_cnt, err_cnt, pass, done);
    end
  endtask

  task automatic test_injected_fault();
    int j;
    logic [4:0] zz;
    do_start(3'd2);
    for (int i = 0; i < 10; i++) begin
      j = (i + 7) % 10;
      zz = TXOR[j];
      if (i == 3) zz = 5'h14;
      if (i == 7) zz = 5'h1F;
      sample(TA[j], TB[j], zz);
      if (i == 3) begin
        vectors++;
        if (err_cnt !== 8'd1 || first_err_idx !== 8'd3 || first_err_exp !== 5'h15 || first_err_got !== 5'h14) begin
          miscompares++;
          $display("FAIL xor_first_fault: err_cnt=%0d idx=%0d exp=%h got=%h, want 1 3 15 14",
                   err_cnt, first_err_idx, first_err_exp, first_err_got);
        end
      end
    end
    vectors++;
    if (done !== 1'b1 || pass !== 1'b0 || err_cnt !== 8'd2 || sample_cnt !== 8'd10) begin
      miscompares++;
      $display("FAIL xor_done: done=%b pass=%b err_cnt=%0d sample_cnt=%0d, want 1 0 2 10",
               done, pass, err_cnt, sample_cnt);
    end
    vectors++;
    if (first_err_idx !== 8'd3 || first_err_exp !== 5'h15 || first_err_got !== 5'h14) begin
      miscompares++;
      $display("FAIL xor_first_held: idx=%0d exp=%h got=%h, want 3 15 14", first_err_idx, first_err_exp, first_err_got);
    end
  endtask

  task automatic test_back_to_back();
    // start with a simultaneous bad sample: start wins and the sample is dropped
    start = 1'b1; op = 3'd3; in_valid = 1'b1; a = 5'h1F; b = 5'h01; z = 5'h00;
    cyc();
    start = 1'b0; in_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0 || sample_cnt !== 8'd0 || err_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL restart_clear: busy=%b done=%b pass=%b sample_cnt=%0d err_cnt=%0d, want 1 0 0 0 0",
               busy, done, pass, sample_cnt, err_cnt);
    end
    vectors++;
    if ({first_err_idx, first_err_exp, first_err_got} !== '0) begin
      miscompares++;
      $display("FAIL restart_first_err: idx=%0d exp=%h got=%h, want 0", first_err_idx, first_err_exp, first_err_got);
    end
    for (int i = 0; i < 5; i++) sample(5'h1F, 5'h01, 5'h1E);
    // start pulse in RUN with a different op must not restart or relatch
    do_start(3'd0);
    start = 1'b1; op = 3'd0;
    sample(5'h1F, 5'h01, 5'h1E);
    start = 1'b0;
    vectors++;
    if (sample_cnt !== 8'd6 || err_cnt !== 8'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_in_run: sample_cnt=%0d err_cnt=%0d busy=%b, want 6 0 1", sample_cnt, err_cnt, busy);
    end
    for (int i = 0; i < 4; i++) sample(5'h1F, 5'h01, 5'h1E);
    vectors++;
    if (done !== 1'b1 || pass !== 1'b1 || sample_cnt !== 8'd10 || err_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL nand_done: done=%b pass=%b sample_cnt=%0d err_cnt=%0d, want 1 1 10 0",
               done, pass, sample_cnt, err_cnt);
    end
  endtask

  task automatic test_gapped_reset();
    do_start(3'd0);
    for (int i = 0; i < 4; i++) begin
      sample(TA[i], TB[i], (i == 1) ? 5'h00 : TAND[i]);
      cyc();
    end
    vectors++;
    if (sample_cnt !== 8'd4 || err_cnt !== 8'd1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL gapped_count: sample_cnt=%0d err_cnt=%0d busy=%b, want 4 1 1", sample_cnt, err_cnt, busy);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    vectors++;
    if ({busy, done, pass, sample_cnt, err_cnt, first_err_idx, first_err_exp, first_err_got} !== '0) begin
      miscompares++;
      $display("FAIL midrun_reset: busy=%b done=%b pass=%b cnt=%0d err=%0d idx=%0d exp=%h got=%h, want all 0",
               busy, done, pass, sample_cnt, err_cnt, first_err_idx, first_err_exp, first_err_got);
    end
    // without a new start, samples must not count
    sample(5'h01, 5'h01, 5'h01);
    vectors++;
    if (sample_cnt !== 8'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: sample_cnt=%0d busy=%b, want 0 0", sample_cnt, busy);
    end
    do_start(3'd0);
    for (int i = 0; i < 10; i++) begin
      sample(TA[i], TB[i], TAND[i]);
      if (i < 9) cyc();
    end
    vectors++;
    if (done !== 1'b1 || pass !== 1'b1 || sample_cnt !== 8'd10 || err_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL gapped_clean: done=%b pass=%b sample_cnt=%0d err_cnt=%0d, want 1 1 10 0",
               done, pass, sample_cnt, err_cnt);
    end
  endtask

`ifdef GATE_CHECKER_SIGNATURE_EN
  task automatic test_signature();
    do_start(3'd0);
    vectors++;
    if (signature !== 5'h00) begin
      miscompares++;
      $display("FAIL sig_start: signature=%h, want 00", signature);
    end
    sample(5'h1B, 5'h0E, 5'h0A);
    vectors++;
    if (signature !== 5'h0A) begin
      miscompares++;
      $display("FAIL sig_first: signature=%h, want 0a", signature);
    end
    sample(5'h01, 5'h01, 5'h01);
    vectors++;
    if (signature !== 5'h15) begin
      miscompares++;
      $display("FAIL sig_second: signature=%h, want 15", signature);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    vectors++;
    if (signature !== 5'h00) begin
      miscompares++;
      $display("FAIL sig_reset: signature=%h, want 00", signature);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_and();
    test_injected_fault();
    test_back_to_back();
    test_gapped_reset();
`ifdef GATE_CHECKER_SIGNATURE_EN
    test_signature();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
